// File: rtl/uc_multiciclo.sv
// Multicycle control unit for a small RV-style subset: add/sub/addi/ld/sd/beq/bne.
// Sequences fetch/decode/execute/memory/writeback with a memory-wait timeout and a retire counter.
//
//   state  | meaning
//   FETCH  | instruction read; waits for mem_ready, loads IR
//   DECODE | classify instruction fields; illegal -> TRAP
//   EX     | ALU operation; branches resolve and retire here
//   MEM    | data access for ld/sd; sd retires here
//   WB     | register write (ALU or memory data), PC advance, retire
//   TRAP   | sticky halt on illegal instruction or memory timeout
module uc_multiciclo #(
    parameter int CNT_W         = 32,
    parameter int MAX_WAIT      = 16,
    parameter int ENABLE_BRANCH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             reg_we,
    output logic             wb_sel,
    output logic [1:0]       alu_op,
    output logic             illegal,
    output logic             timeout,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);

    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EX     = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic               illegal_q, illegal_d;
    logic               timeout_q, timeout_d;

    logic               is_add, is_sub, is_addi, is_ld, is_sd, is_beq, is_bne;
    logic               is_branch, is_mem, is_legal;
    logic               wait_expired;
    logic [WAIT_W-1:0]  wait_inc;
    logic               retire;

    logic               mem_req_c, mem_we_c, ir_we_c, pc_we_c, pc_sel_c;
    logic               reg_we_c, wb_sel_c;
    logic [1:0]         alu_op_c;

    always_comb begin
        is_add    = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
        is_sub    = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0100000);
        is_addi   = (opcode == 7'b0010011) && (funct3 == 3'b000);
        is_ld     = (opcode == 7'b0000011) && (funct3 == 3'b011);
        is_sd     = (opcode == 7'b0100011) && (funct3 == 3'b011);
        is_beq    = (ENABLE_BRANCH != 0) && (opcode == 7'b1100011) && (funct3 == 3'b000);
        is_bne    = (ENABLE_BRANCH != 0) && (opcode == 7'b1100011) && (funct3 == 3'b001);
        is_branch = is_beq || is_bne;
        is_mem    = is_ld || is_sd;
        is_legal  = is_add || is_sub || is_addi || is_mem || is_branch;
    end

    // A ready in the same cycle as the terminal count still completes the access.
    always_comb begin
        wait_expired = (MAX_WAIT > 0) && (wait_cnt_q == WAIT_MAX);
        wait_inc     = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        instret_d  = instret_q;
        illegal_d  = illegal_q;
        timeout_d  = timeout_q;
        retire     = 1'b0;
        mem_req_c  = 1'b0;
        mem_we_c   = 1'b0;
        ir_we_c    = 1'b0;
        pc_we_c    = 1'b0;
        pc_sel_c   = 1'b0;
        reg_we_c   = 1'b0;
        wb_sel_c   = 1'b0;
        alu_op_c   = 2'd0;

        case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                if (mem_ready) begin
                    ir_we_c = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_expired) begin
                    timeout_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    wait_cnt_d = wait_inc;
                end
            end
            S_DECODE: begin
                if (is_legal) begin
                    state_d = S_EX;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_TRAP;
                end
            end
            S_EX: begin
                alu_op_c = (is_sub || is_branch) ? 2'd2 : 2'd1;
                if (is_branch) begin
                    pc_we_c  = 1'b1;
                    pc_sel_c = (is_beq && zero) || (is_bne && !zero);
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end else if (is_mem) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req_c = 1'b1;
                mem_we_c  = is_sd;
                if (mem_ready) begin
                    if (is_sd) begin
                        pc_we_c = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_expired) begin
                    timeout_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    wait_cnt_d = wait_inc;
                end
            end
            S_WB: begin
                reg_we_c = 1'b1;
                wb_sel_c = is_ld;
                pc_we_c  = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM))) begin
            wait_cnt_d = '0;
        end
        if (retire) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
            instret_q  <= '0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            instret_q  <= instret_d;
            illegal_q  <= illegal_d;
            timeout_q  <= timeout_d;
        end
    end

    // Held low, reset forces every strobe off even though FETCH would request memory.
    assign mem_req = mem_req_c & reset;
    assign mem_we  = mem_we_c  & reset;
    assign ir_we   = ir_we_c   & reset;
    assign pc_we   = pc_we_c   & reset;
    assign pc_sel  = pc_sel_c  & reset;
    assign reg_we  = reg_we_c  & reset;
    assign wb_sel  = wb_sel_c  & reset;
    assign alu_op  = alu_op_c  & {2{reset}};
    assign illegal = illegal_q;
    assign timeout = timeout_q;
    assign state   = state_q;
    assign instret = instret_q;

endmodule
